// File: rtl/conv_pkg.sv
// Shared definitions for the convolution image loader: loader state encoding
// and the size helpers that derive pixel count and counter width.
package conv_pkg;

    // LOAD: collecting pixels; FULL: complete frame presented to the conv layer.
    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    // Number of pixels in one D x H x W frame.
    function automatic int pix_count(input int d, input int h, input int w);
        return d * h * w;
    endfunction

    // Counter width able to hold 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/conv_img_loader.sv
// conv_img_loader: streams pixels in channel-row-column order into the flat
// img vector of the conv layer and holds the conv layer in reset until a full
// frame is present.
//
// Optional feature: CONV_IMG_LOADER_LAST_CHK_EN enables the s_last framing
// check driving the sticky err output. Without it s_last is ignored and err
// is tied low.
//
// Handshake: a beat transfers on a rising clk edge where s_valid and s_ready
// are both high; s_ready is decoded from registered state only, so the source
// may hold s_valid/s_data until it sees the transfer, and the loader never
// depends combinationally on s_valid or img_ack.
import conv_pkg::*;

module conv_img_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    output logic                            s_ready,
    output logic [0:D*H*W*DATA_WIDTH-1]     img,
    output logic                            img_valid,
    input  logic                            img_ack,
    output logic                            conv_rst,
    output logic                            err
);

    localparam int N  = pix_count(D, H, W);
    localparam int CW = cnt_width(N);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_beat;

    assign accept    = s_valid & s_ready;
    assign last_beat = (cnt == CW'(N - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // Next state: the N-th accepted beat fills the frame, an ack releases it.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: if (accept && last_beat) state_nxt = FULL;
            FULL: if (img_ack)             state_nxt = LOAD;
            default:                       state_nxt = LOAD;
        endcase
    end

    // Outputs decoded purely from the registered state.
    always_comb begin
        s_ready   = 1'b0;
        img_valid = 1'b0;
        conv_rst  = 1'b1;
        case (state)
            LOAD: begin
                s_ready   = 1'b1;
                img_valid = 1'b0;
                conv_rst  = 1'b1;
            end
            FULL: begin
                s_ready   = 1'b0;
                img_valid = 1'b1;
                conv_rst  = 1'b0;
            end
            default: begin
                s_ready   = 1'b0;
                img_valid = 1'b0;
                conv_rst  = 1'b1;
            end
        endcase
    end

    // Pixel write and slot counter; slots are overwritten, never cleared, between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            img <= '0;
        end else if (accept) begin
            img[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            cnt <= last_beat ? '0 : cnt + CW'(1);
        end
    end

`ifdef CONV_IMG_LOADER_LAST_CHK_EN
    // Sticky framing error: s_last must coincide exactly with the N-th beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              err <= 1'b0;
        else if (accept && (s_last != last_beat)) err <= 1'b1;
    end
`else
    // Framing check disabled: s_last is deliberately left unobserved.
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_conv_img_loader.sv
// Testbench for conv_img_loader (DATA_WIDTH=8, D=1, H=4, W=4, N=16).
// Reference model: a 16-entry pixel array, a beat counter and a full flag,
// updated from the documented accept/ack rules; completed frames are also
// checked slot by slot against a queue of accepted pixels.
module tb_conv_img_loader;

    localparam int DW = 8;
    localparam int NP = 16;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_last;
    logic            s_ready;
    logic [0:NP*DW-1] img;
    logic            img_valid;
    logic            img_ack;
    logic            conv_rst;
    logic            err;

    conv_img_loader #(
        .DATA_WIDTH(DW), .D(1), .H(4), .W(4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .img      (img),
        .img_valid(img_valid),
        .img_ack  (img_ack),
        .conv_rst (conv_rst),
        .err      (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model / scoreboard ----------------
    int              checks = 0;
    int              errors = 0;
    logic [DW-1:0]   m_img [NP];
    int              m_cnt;
    bit              m_full;
    bit              m_err;
    bit              frame_done;
    logic [DW-1:0]   exp_q[$];
    int              cyc_n;
    logic            prev_valid;
    int              rise_cyc[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NP; k++) m_img[k] = '0;
        m_cnt  = 0;
        m_full = 0;
        m_err  = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [DW-1:0] d, input logic last, input logic ack);
        frame_done = 0;
        if (!m_full) begin
            if (v) begin
`ifdef CONV_IMG_LOADER_LAST_CHK_EN
                if (last != (m_cnt == NP - 1)) m_err = 1;
`endif
                m_img[m_cnt] = d;
                exp_q.push_back(d);
                m_cnt++;
                if (m_cnt == NP) begin
                    m_cnt      = 0;
                    m_full     = 1;
                    frame_done = 1;
                end
            end
        end else if (ack) begin
            m_full = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [0:NP*DW-1] exp_img;
        for (int k = 0; k < NP; k++) exp_img[k*DW +: DW] = m_img[k];
        check({tag, ".s_ready"},   128'(s_ready),   128'(!m_full));
        check({tag, ".img_valid"}, 128'(img_valid), 128'(m_full));
        check({tag, ".conv_rst"},  128'(conv_rst),  128'(!m_full));
        check({tag, ".img"},       128'(img),       128'(exp_img));
        check({tag, ".err"},       128'(err),       128'(m_err));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic last, input logic ack);
        s_valid = v;
        s_data  = d;
        s_last  = last;
        img_ack = ack;
        @(posedge clk);
        #1;
        cyc_n++;
        model_step(v, d, last, ack);
        check_outputs("cyc");
        if (frame_done) begin
            for (int k = 0; k < NP; k++) begin
                if (exp_q.size() == 0) check("frame_q_empty", 128'(1), 128'(0));
                else check("frame_pix", 128'(img[k*DW +: DW]), 128'(exp_q.pop_front()));
            end
        end
        if (img_valid && !prev_valid) rise_cyc.push_back(cyc_n);
        prev_valid = img_valid;
        s_valid = 1'b0;
        s_last  = 1'b0;
        img_ack = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs("rst_on");
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_valid = img_valid;
        #1;
        check_outputs("rst_off");
    endtask

    // Load one frame of base+i; gap toggles s_valid; bad_idx marks an extra s_last.
    task automatic load_frame(input logic [DW-1:0] base, input bit gap, input int bad_idx);
        int acc;
        logic v;
        acc = 0;
        for (int t = 0; t < 64 && acc < NP; t++) begin
            v = gap ? logic'(t % 2) : 1'b1;
            cycle(v, base + DW'(acc), (acc == NP - 1) || (acc == bad_idx), 1'b0);
            if (v) acc++;
        end
        check("load_done", 128'(acc), 128'(NP));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; img_ack = 1'b0;
        cyc_n = 0; prev_valid = 1'b0; frame_done = 0;
        model_reset();
        #3;
        do_reset();

        // Back-to-back frame 0x00..0x0F.
        load_frame(8'h00, 1'b0, -1);
        check("bb_pix0",  128'(img[0:7]),     128'(8'h00));
        check("bb_pix15", 128'(img[120:127]), 128'(8'h0F));

        // Beats offered while FULL must be ignored.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Gapped frame with the same contents.
        load_frame(8'h00, 1'b1, -1);
        check("gap_pix0",  128'(img[0:7]),     128'(8'h00));
        check("gap_pix15", 128'(img[120:127]), 128'(8'h0F));
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset after seven beats discards the partial frame.
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        do_reset();
        load_frame(8'h10, 1'b0, -1);
        check("rl_pix0", 128'(img[0:7]), 128'(8'h10));
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // s_last on beat 9 (sets err only when the check is built in).
        load_frame(8'h40, 1'b0, 8);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        do_reset();
        load_frame(8'h50, 1'b0, -1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Two frames at the minimum period.
        rise_cyc.delete();
        load_frame(8'h60, 1'b0, -1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        load_frame(8'h70, 1'b0, -1);
        if (rise_cyc.size() >= 2) check("period", 128'(rise_cyc[1] - rise_cyc[0]), 128'(17));
        else check("period_rises", 128'(rise_cyc.size()), 128'(2));

        // Randomized traffic with random acks and s_last.
        for (int i = 0; i < 400; i++)
            cycle(logic'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 2) == 0));
        do_reset();
        for (int i = 0; i < 200; i++)
            cycle(logic'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                  1'b0, logic'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
